// File: rtl/mlop_accum.sv
// rtl/mlop_accum.sv - frame accumulator summing FRAME_LEN samples per frame
//
// Purpose:
//   Takes unsigned samples on a valid/ready handshake, holds each one for a
//   cycle in a stage register, and adds it into an ACC_W accumulator. When a
//   frame of FRAME_LEN samples is complete the total goes to sum and sum_vld
//   pulses for one cycle.
//
// Optional feature:
//   MLOP_ACC_SAT_EN - when defined, an overflowing add saturates acc (and sum)
//   to all-ones and sets the sticky ovf flag. When undefined, acc wraps
//   modulo 2^ACC_W and ovf stays 0.
//
// Ports:
//   clk      in   1      clock, rising edge
//   rst_b    in   1      asynchronous reset, active low
//   start    in   1      begin a frame (only sampled in IDLE)
//   clr      in   1      synchronous abort/clear, wins over start
//   x        in   IN_W   sample data
//   x_vld    in   1      sample valid
//   x_rdy    out  1      ready, high only in RUN
//   acc      out  ACC_W  running accumulator
//   cnt      out  CNT_W  samples accepted this frame
//   sum      out  ACC_W  last completed frame total
//   sum_vld  out  1      one-cycle pulse when sum updates
//   busy     out  1      high in RUN and DRAIN
//   ovf      out  1      sticky overflow flag
module mlop_accum #(
  parameter int IN_W      = 10,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 100,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             clr,
  input  logic [IN_W-1:0]  x,
  input  logic             x_vld,
  output logic             x_rdy,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] cnt,
  output logic [ACC_W-1:0] sum,
  output logic             sum_vld,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [IN_W-1:0]  s_q, s_d;
  logic             s_vld_q, s_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sum_vld_q, sum_vld_d;
  logic             ovf_q, ovf_d;

  logic             hs;
  logic [ACC_W-1:0] add_res;
  logic             add_ovf;

`ifdef MLOP_ACC_SAT_EN
  logic [ACC_W:0] add_full;

  // One extra bit catches the carry; a saturated acc stays all-ones because
  // any non-zero sample carries again and a zero sample leaves it unchanged.
  always_comb begin
    add_full = {1'b0, acc_q} + (ACC_W + 1)'(s_q);
    add_ovf  = add_full[ACC_W];
    add_res  = add_ovf ? '1 : add_full[ACC_W-1:0];
  end
`else
  always_comb begin
    add_ovf = 1'b0;
    add_res = acc_q + ACC_W'(s_q);
  end
`endif

  assign hs = (state_q == S_RUN) && x_vld;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    s_vld_d   = 1'b0;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    sum_vld_d = 1'b0;
    ovf_d     = ovf_q;

    // The stage register drains into acc on every edge it holds a sample,
    // independent of state; the FSM only decides what gets loaded behind it.
    if (s_vld_q) begin
      acc_d = add_res;
      if (add_ovf) begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (hs) begin
          s_d     = x;
          s_vld_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The last sample is still in the stage register here.
        sum_d     = add_res;
        sum_vld_d = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (clr) begin
      state_d   = S_IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      s_vld_d   = 1'b0;
      ovf_d     = 1'b0;
      sum_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      s_q       <= '0;
      s_vld_q   <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      s_vld_q   <= s_vld_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign x_rdy   = (state_q == S_RUN);
  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign acc     = acc_q;
  assign cnt     = cnt_q;
  assign sum     = sum_q;
  assign sum_vld = sum_vld_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mlop_accum.sv
// tb/tb_mlop_accum.sv - scoreboard bench for mlop_accum
module tb_mlop_accum;

  localparam int IN_W      = 10;
  localparam int ACC_W     = 16;
  localparam int FRAME_LEN = 100;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             start = 1'b0;
  logic             clr = 1'b0;
  logic [IN_W-1:0]  x = '0;
  logic             x_vld = 1'b0;
  logic             x_rdy;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum;
  logic             sum_vld;
  logic             busy;
  logic             ovf;

  always #5 clk = ~clk;

  mlop_accum #(
    .IN_W(IN_W),
    .ACC_W(ACC_W),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .start(start),
    .clr(clr),
    .x(x),
    .x_vld(x_vld),
    .x_rdy(x_rdy),
    .acc(acc),
    .cnt(cnt),
    .sum(sum),
    .sum_vld(sum_vld),
    .busy(busy),
    .ovf(ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    longint sum;
    bit     ovf;
  } exp_t;

  exp_t   sb[$];
  longint last_sum = 0;
  int     cyc = 0;
  int     last_acc = -100;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: true frame total, then either clipped or reduced modulo 2^ACC_W.
  task automatic push_exp(input longint total);
    exp_t e;
`ifdef MLOP_ACC_SAT_EN
    e.sum = (total > ACC_MAX) ? ACC_MAX : total;
    e.ovf = (total > ACC_MAX);
`else
    e.sum = total % (ACC_MAX + 1);
    e.ovf = 1'b0;
`endif
    last_sum = e.sum;
    sb.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: an accept seen here lands on the coming edge (cyc+1); sum_vld is
  // raised by edge last_acc+1, so a consumer samples it at edge last_acc+2.
  initial begin
    exp_t e;
    bit   prev_vld;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_b && x_vld && x_rdy) last_acc = cyc + 1;
      if (prev_vld) check("sum_vld_one_cycle", sum_vld, 0);
      if (sum_vld) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_sum_vld: got sum %0d, expected no pulse", sum);
        end else begin
          e = sb.pop_front();
          check("sum", sum, e.sum);
          check("acc_eq_sum", acc, e.sum);
          check("cnt_at_done", cnt, FRAME_LEN);
          check("ovf", ovf, e.ovf);
          check("sum_vld_latency", cyc - last_acc, 1);
        end
      end
      prev_vld = sum_vld;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [IN_W-1:0] v, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      x_vld = 1'b0;
      x = IN_W'($urandom);
      tick();
    end
    x = v;
    x_vld = 1'b1;
    tick();
    x_vld = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sum_vld_timeout: got no pulse in 20 cycles, expected %0d", sb[0].sum);
      sb.delete();
    end
    tick();
    check("busy_after_done", busy, 0);
    check("cnt_hold_idle", cnt, FRAME_LEN);
  endtask

  // mode: 0 odd numbers, 1 all 1023, 2 all ones, 3 random
  // gapmode: 0 none, 1 every other cycle, 2 random 0..2 idle cycles
  task automatic run_frame(input int mode, input int gapmode, input bit poke_start);
    longint total;
    logic [IN_W-1:0] v;
    int gaps;
    total = 0;
    begin_frame();
    for (int j = 0; j < FRAME_LEN; j++) begin
      case (mode)
        0: v = IN_W'(2 * j + 1);
        1: v = IN_W'(1023);
        2: v = IN_W'(1);
        default: v = IN_W'($urandom);
      endcase
      total += longint'(v);
      if (j == FRAME_LEN - 1) push_exp(total);
      gaps = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : $urandom_range(0, 2);
      start = poke_start && (j < FRAME_LEN - 1) && ($urandom_range(0, 1) == 1);
      send(v, gaps);
      check("cnt_per_accept", cnt, j + 1);
    end
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1 ms, expected earlier finish");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0;
    #25;
    check("rst_acc", acc, 0);
    check("rst_cnt", cnt, 0);
    check("rst_sum", sum, 0);
    check("rst_sum_vld", sum_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_x_rdy", x_rdy, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    run_frame(0, 0, 0);
    run_frame(0, 1, 0);
    run_frame(1, 0, 0);

    begin_frame();
    for (int j = 0; j < 40; j++) send(IN_W'($urandom), 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_x_rdy", x_rdy, 0);
    check("clr_acc", acc, 0);
    check("clr_cnt", cnt, 0);
    check("clr_ovf", ovf, 0);
    check("clr_sum_kept", sum, last_sum);
    start = 1'b1;
    clr = 1'b1;
    tick();
    start = 1'b0;
    clr = 1'b0;
    check("start_clr_idle", busy, 0);
    check("start_clr_x_rdy", x_rdy, 0);
    run_frame(2, 0, 0);

    begin_frame();
    for (int j = 0; j < 50; j++) send(IN_W'($urandom), 0);
    #3;
    rst_b = 1'b0;
    #1;
    check("arst_acc", acc, 0);
    check("arst_cnt", cnt, 0);
    check("arst_sum", sum, 0);
    check("arst_busy", busy, 0);
    check("arst_x_rdy", x_rdy, 0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    run_frame(3, 2, 1);
    run_frame(3, 0, 1);
    run_frame(3, 2, 0);

    tick();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
